// File: rtl/add_seq_cla16.sv
// Multi-cycle (16*WORDS)-bit adder: one cla16 slice per cycle, LSB first.
// Optional subtract mode via `define ADD_SEQ_SUB_EN (adds port sub).

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co,
  output logic        gg,
  output logic        pg
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gk;
  logic [3:0]  pk;
  logic [4:0]  gc;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit group generate/propagate
  always_comb begin
    gk = '0;
    pk = '0;
    for (int i = 0; i < 4; i++) begin
      gk[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      pk[i] = &p[4*i +: 4];
    end
  end

  // group carries computed in parallel from ci
  always_comb begin
    gc    = '0;
    gc[0] = ci;
    gc[1] = gk[0] | (pk[0] & ci);
    gc[2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ci);
    gc[3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
          | (pk[2] & pk[1] & pk[0] & ci);
    gc[4] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
          | (pk[3] & pk[2] & pk[1] & gk[0])
          | (pk[3] & pk[2] & pk[1] & pk[0] & ci);
  end

  // bit carries inside each group seeded by the group carry
  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i] = gc[i];
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
      end
    end
    c[16] = gc[4];
  end

  assign s  = p ^ c[15:0];
  assign co = c[16];
  assign gg = gc[4] & ~(&pk & ci) | (gk[3] | (pk[3] & gk[2])
            | (pk[3] & pk[2] & gk[1]) | (pk[3] & pk[2] & pk[1] & gk[0]));
  assign pg = &pk;

endmodule

module add_seq_cla16 #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  ci,
`ifdef ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  co,
  output logic                  ovf,
  output logic                  busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [WORDS-1:0][15:0]   op_a;
  logic [WORDS-1:0][15:0]   op_b;
  logic [WORDS-1:0][15:0]   sum_r;
  logic                     carry;
  logic [IW-1:0]            idx;
  logic [16*WORDS-1:0]      b_in;
  logic                     c_in;
  logic [15:0]              ss;
  logic                     sco;
  logic                     unused_gg;
  logic                     unused_pg;
  logic                     last;

`ifdef ADD_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : ci;
`else
  assign b_in = b;
  assign c_in = ci;
`endif

  assign last = (idx == IW'(WORDS - 1));
  assign sum  = sum_r;

  cla16 u_cla (
    .a  (op_a[idx]),
    .b  (op_b[idx]),
    .ci (carry),
    .s  (ss),
    .co (sco),
    .gg (unused_gg),
    .pg (unused_pg)
  );

  // sequencer: accept, one slice per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum_r     <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b_in;
            carry    <= c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= ss;
          carry      <= sco;
          if (last) begin
            co        <= sco;
            ovf       <= (op_a[WORDS-1][15] == op_b[WORDS-1][15])
                      && (ss[15] != op_a[WORDS-1][15]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_cla16.sv
// Scoreboard bench for add_seq_cla16 (WORDS=4).
// Define ADD_SEQ_SUB_EN to also exercise subtract mode.

module tb_add_seq_cla16;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
`ifdef ADD_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;
  logic         busy;

  add_seq_cla16 #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv);
    logic [W:0] t;
    res_t       r;
    t   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (av[W-1] == bv[W-1]) && (r.s[W-1] != av[W-1]);
    return r;
  endfunction

  // drive one request, wait (bounded) for accept, push expected result
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic cv, input logic sv,
                      output int acc, output bit ok);
    a = av;
    b = bv;
    ci = cv;
`ifdef ADD_SEQ_SUB_EN
    sub = sv;
`endif
    in_valid = 1'b1;
    ok = 1'b0;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      exp_q.push_back(sv ? model(av, ~bv, 1'b1) : model(av, bv, cv));
      @(posedge clk);
      #1 acc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    ci = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // wait (bounded) for a result, sample it, let the handoff edge pass
  task automatic collect(output res_t r, output int vc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vc = cyc;
    r = '{sum, co, ovf};
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, co, ovf} !== 5'b10000 || sum !== '0) begin
      bad++;
      $display("FAIL reset_vals got rdy=%b vld=%b busy=%b co=%b ovf=%b sum=%h want 1 0 0 0 0 0",
               in_ready, out_valid, busy, co, ovf, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    int acc, vc;
    bit ok;
    res_t r, e;
    out_ready = 1'b1;
    send(64'h1, 64'h2, 1'b0, 1'b0, acc, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_accept got timeout want accept");
    end
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    collect(r, vc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL basic_result got %h/%b/%b want %h/%b/%b", r.s, r.c, r.o, e.s, e.c, e.o);
    end
    total++;
    if (vc - acc !== WORDS) begin
      bad++;
      $display("FAIL basic_latency got %0d want %0d", vc - acc, WORDS);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_handoff got rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_carry_ovf;
    logic [W-1:0] ta [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'h0000_FFFF_0000_FFFF};
    logic [W-1:0] tb [4] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_0001};
    logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int acc, vc;
    bit ok, ok2;
    res_t r, e;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(ta[k], tb[k], tc[k], 1'b0, acc, ok);
      collect(r, vc, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok || !ok2 || r !== e) begin
        bad++;
        $display("FAIL carry_ovf[%0d] got %h/%b/%b want %h/%b/%b",
                 k, r.s, r.c, r.o, e.s, e.c, e.o);
      end
    end
  endtask

  task automatic test_backpressure;
    int acc, vc;
    bit ok;
    res_t r0, r, e;
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, acc, ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_wait got timeout want out_valid");
    end
    r0 = '{sum, co, ovf};
    a = 64'h0000_0000_0000_00AA;
    b = 64'h0000_0000_0000_0055;
    ci = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (res_t'({sum, co, ovf}) !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d] got %h/%b/%b rdy=%b vld=%b want %h/%b/%b 0 1",
                 k, sum, co, ovf, in_ready, out_valid, r0.s, r0.c, r0.o);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (r0 !== e) begin
      bad++;
      $display("FAIL bp_result got %h/%b/%b want %h/%b/%b", r0.s, r0.c, r0.o, e.s, e.c, e.o);
    end
    out_ready = 1'b1;
    send(64'h0000_0000_0000_00AA, 64'h0000_0000_0000_0055, 1'b0, 1'b0, acc, ok);
    collect(r, vc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL bp_next got %h/%b/%b want %h/%b/%b", r.s, r.c, r.o, e.s, e.c, e.o);
    end
  endtask

  task automatic test_reset_mid;
    int acc, vc, seen;
    bit ok;
    res_t r, e;
    out_ready = 1'b1;
    send(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b0, 1'b0, acc, ok);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    total++;
    if ({in_ready, out_valid, busy, co, ovf} !== 5'b10000 || sum !== '0) begin
      bad++;
      $display("FAIL rstmid_vals got rdy=%b vld=%b busy=%b co=%b ovf=%b sum=%h want 1 0 0 0 0 0",
               in_ready, out_valid, busy, co, ovf, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rstmid_novalid got %0d pulses want 0", seen);
    end
    send(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, acc, ok);
    collect(r, vc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL rstmid_fresh got %h/%b/%b want %h/%b/%b", r.s, r.c, r.o, e.s, e.c, e.o);
    end
  endtask

  task automatic test_back_to_back;
    int acc, prev, vc;
    bit ok, ok2;
    res_t r, e;
    out_ready = 1'b1;
    prev = -1;
    for (int n = 0; n < 6; n++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, acc, ok);
      if (n > 0) begin
        total++;
        if (acc - prev !== WORDS + 2) begin
          bad++;
          $display("FAIL b2b_rate[%0d] got %0d want %0d", n, acc - prev, WORDS + 2);
        end
      end
      prev = acc;
      collect(r, vc, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok || !ok2 || r !== e) begin
        bad++;
        $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b",
                 n, r.s, r.c, r.o, e.s, e.c, e.o);
      end
    end
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub;
    int acc, vc;
    bit ok, ok2;
    res_t r, e;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) send(64'h5, 64'h7, 1'b0, 1'b1, acc, ok);
      else send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, acc, ok);
      collect(r, vc, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok || !ok2 || r !== e) begin
        bad++;
        $display("FAIL sub[%0d] got %h/%b/%b want %h/%b/%b",
                 n, r.s, r.c, r.o, e.s, e.c, e.o);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
